// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared definitions for the unified memory port arbiter
package mips_defs;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Access size encoding shared by the load/store controller and the RAM
    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b10;
    localparam logic [1:0] NONE = 2'b11;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IF_WAIT  = 3'd1,
        ARB_MEM_WAIT = 3'd2,
        ARB_IF_DONE  = 3'd3,
        ARB_MEM_DONE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of MEM grants taken while IF waits
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic full
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign full = (cnt_q == MAX_V);

    // Clear wins over increment; the count sticks at MAX until IF is served
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !full) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between instruction fetch and load/store
module mem_port_arbiter
    import mips_defs::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [1:0]        mem_ls_bit,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [1:0]        ram_ls_bit,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    arb_state_t        state_q, state_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [1:0]        ram_ls_q, ram_ls_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic starve_full;
    logic mem_win;
    logic in_idle;

    // MEM wins unless IF has already been passed over MAX_MEM_BURST times
    assign in_idle = (state_q == ARB_IDLE);
    assign mem_win = (mem_rd | mem_wr) && !(if_req && starve_full);

    arb_starve_cnt #(
        .MAX (MAX_MEM_BURST)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_idle && mem_win && if_req),
        .clr   (in_idle && !mem_win && if_req),
        .full  (starve_full)
    );

    // Arbitration, RAM handshake and read-data capture
    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_ls_d    = ram_ls_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_win) begin
                    state_d     = ARB_MEM_WAIT;
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_wr;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    ram_ls_d    = mem_ls_bit;
                end else if (if_req) begin
                    state_d     = ARB_IF_WAIT;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                    ram_ls_d    = WORD;
                end
            end
            ARB_IF_WAIT: begin
                if (ram_ack) begin
                    state_d    = ARB_IF_DONE;
                    ram_req_d  = 1'b0;
                    if_rdata_d = ram_rdata;
                end
            end
            ARB_MEM_WAIT: begin
                if (ram_ack) begin
                    state_d   = ARB_MEM_DONE;
                    ram_req_d = 1'b0;
                    if (!ram_we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                end
            end
            // The ready cycle never arbitrates, so a lingering request is not re-granted
            ARB_IF_DONE, ARB_MEM_DONE: state_d = ARB_IDLE;
            default:                   state_d = ARB_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_ls_q    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_ls_q    <= ram_ls_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_req    = ram_req_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_ls_bit = ram_ls_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = (state_q == ARB_IF_DONE);
    assign mem_ready  = (state_q == ARB_MEM_DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_ls_bit;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [1:0]  ram_ls_bit;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_MEM_BURST(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ls_bit(mem_ls_bit), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ls_bit(ram_ls_bit), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: phase 0 = port free, 1 = access outstanding, 2 = ready cycle
    int          ph = 0;
    bit          m_mem;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_ls;
    logic [31:0] m_if_rdata = '0, m_mem_rdata = '0;
    int          m_starve = 0;

    logic [31:0] grant_q[$];
    logic        last_ram_req = 1'b0;
    bit          saw_mem_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: capture what the DUT sees at the edge, advance the model, compare
    task automatic cycle();
        logic        p_rst, p_if, p_rd, p_wr, p_ack;
        logic [31:0] p_ia, p_ma, p_wd, p_rdat;
        logic [1:0]  p_ls;
        p_rst = rst_n; p_if = if_req; p_rd = mem_rd; p_wr = mem_wr; p_ack = ram_ack;
        p_ia = if_addr; p_ma = mem_addr; p_wd = mem_wdata; p_rdat = ram_rdata; p_ls = mem_ls_bit;
        @(posedge clk);
        #1;
        if (!p_rst) begin
            ph = 0; m_starve = 0; m_if_rdata = '0; m_mem_rdata = '0;
        end else if (ph == 0) begin
            if ((p_rd || p_wr) && !(p_if && m_starve == MAX)) begin
                m_mem = 1'b1; m_we = p_wr; m_addr = p_ma; m_wdata = p_wd; m_ls = p_ls;
                if (p_if && m_starve < MAX) m_starve++;
                ph = 1;
            end else if (p_if) begin
                m_mem = 1'b0; m_we = 1'b0; m_addr = p_ia; m_ls = 2'b00;
                m_starve = 0;
                ph = 1;
            end
        end else if (ph == 1) begin
            if (p_ack) begin
                ph = 2;
                if (!m_mem) m_if_rdata = p_rdat;
                else if (!m_we) m_mem_rdata = p_rdat;
            end
        end else begin
            ph = 0;
        end
        chk("ram_req", ram_req, ph == 1);
        if (ph == 1) begin
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_we", ram_we, m_we);
            chk("ram_ls_bit", ram_ls_bit, m_ls);
            if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
        end
        chk("if_ready", if_ready, ph == 2 && !m_mem);
        chk("mem_ready", mem_ready, ph == 2 && m_mem);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("mem_rdata", mem_rdata, m_mem_rdata);
        if (ram_req && !last_ram_req) grant_q.push_back(ram_addr);
        last_ram_req = ram_req;
        if (mem_ready) saw_mem_ready = 1'b1;
    endtask

    // Wait for the next grant, ack after k cycles, land on the ready cycle
    task automatic serve(input int k, input logic [31:0] data);
        int t;
        t = 0;
        while (!ram_req && t < 50) begin
            ram_ack = 1'b0; cycle(); t++;
        end
        chk("grant_timeout", ram_req, 1'b1);
        ram_ack = 1'b0;
        repeat (k) cycle();
        ram_ack = 1'b1; ram_rdata = data;
        cycle();
        ram_ack = 1'b0;
        chk("ready_seen", if_ready | mem_ready, 1'b1);
    endtask

    task automatic new_mem();
        {mem_wr, mem_rd} = 2'($urandom_range(1, 3));
        mem_addr   = $urandom;
        mem_wdata  = $urandom;
        mem_ls_bit = 2'($urandom_range(0, 3));
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] keep;
        int t;

        // Reset held with a fetch pending: nothing leaves the block
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0040;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_ls_bit = 2'b00;
        ram_rdata = '0; ram_ack = 1'b0;
        cycle(); cycle();
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_ram_ls", ram_ls_bit, 2'b00);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_req", ram_req, 1'b1);
        chk("post_rst_addr", ram_addr, 32'h0000_0040);
        ram_ack = 1'b1; ram_rdata = 32'h1111_1111;
        cycle();
        ram_ack = 1'b0; if_req = 1'b0;
        cycle();

        // Fetch latency: k=3 gives ready five cycles after the request
        if_req = 1'b1; if_addr = 32'h0000_0400;
        cycle(); t = 1;
        while (!if_ready && t < 20) begin
            ram_ack = (t == 4); ram_rdata = 32'h2402_000A;
            cycle(); t++;
        end
        chk("if_latency", t, 5);
        chk("if_word", if_rdata, 32'h2402_000A);
        ram_ack = 1'b0; if_req = 1'b0;
        cycle();

        // Simultaneous store and fetch: store first, fetch right after
        grant_q.delete();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_wr = 1'b1; mem_rd = 1'b1; mem_addr = 32'h0000_0100;
        mem_wdata = 32'hDEAD_BEEF; mem_ls_bit = 2'b10;
        cycle();
        chk("store_we", ram_we, 1'b1);
        chk("store_ls", ram_ls_bit, 2'b10);
        serve(0, 32'h5555_5555);
        chk("store_ready", mem_ready, 1'b1);
        mem_wr = 1'b0; mem_rd = 1'b0;
        serve(1, 32'h0C00_0001);
        chk("fetch_after_store", if_ready, 1'b1);
        chk("grant_order_n", grant_q.size(), 2);
        if (grant_q.size() == 2) chk("grant1_if", grant_q[1], 32'h0000_0200);

        // Starvation guard: 4 loads, 1 fetch, repeat
        grant_q.delete();
        mem_rd = 1'b1; mem_addr = 32'h0000_0300; mem_ls_bit = 2'b00;
        for (int i = 0; i < 12; i++) serve(0, $urandom);
        exp_q = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200,
                  32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300, 32'h300};
        chk("starve_n", grant_q.size(), 12);
        for (int i = 0; i < 12 && i < grant_q.size(); i++) chk("starve_seq", grant_q[i], exp_q[i]);

        // Spurious ack in IDLE changes nothing
        mem_rd = 1'b0; if_req = 1'b0;
        cycle();
        keep = mem_rdata;
        ram_ack = 1'b1; ram_rdata = 32'hBAD0_BAD0;
        cycle(); cycle();
        ram_ack = 1'b0;
        chk("idle_ack_rdata", mem_rdata, keep);
        chk("idle_ack_ready", if_ready | mem_ready, 1'b0);

        // Ack repeated into the ready cycle is ignored
        mem_rd = 1'b1; mem_addr = 32'h0000_0700;
        serve(1, 32'hCAFE_0001);
        mem_rd = 1'b0;
        ram_ack = 1'b1; ram_rdata = 32'hBAD1_BAD1;
        cycle();
        ram_ack = 1'b0;
        cycle();
        chk("done_ack_rdata", mem_rdata, 32'hCAFE_0001);

        // Reset in MEM_WAIT, then a late ack; starvation count starts over
        mem_rd = 1'b1; if_req = 1'b1;
        cycle(); cycle();
        rst_n = 1'b0;
        saw_mem_ready = 1'b0;
        cycle();
        chk("rst_wait_req", ram_req, 1'b0);
        rst_n = 1'b1; mem_rd = 1'b0; if_req = 1'b0; ram_ack = 1'b1; ram_rdata = 32'hBAD2_BAD2;
        cycle();
        ram_ack = 1'b0;
        cycle(); cycle();
        chk("rst_no_ready", saw_mem_ready, 1'b0);
        grant_q.delete();
        mem_rd = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 5; i++) serve(0, $urandom);
        chk("rst_starve_n", grant_q.size(), 5);
        if (grant_q.size() == 5) chk("rst_starve_if5", grant_q[4], 32'h0000_0200);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) chk("rst_starve_mem", grant_q[i], 32'h700);
        mem_rd = 1'b0; if_req = 1'b0;
        cycle();

        // Randomized traffic against the reference
        for (int c = 0; c < 2000; c++) begin
            if (if_ready) begin
                if_req = 1'b0;
                if ($urandom_range(0, 1) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end else if (if_req && ph == 1 && !m_mem && $urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (mem_ready) begin
                mem_rd = 1'b0; mem_wr = 1'b0;
                if ($urandom_range(0, 1) == 0) new_mem();
            end else if (!(mem_rd | mem_wr) && $urandom_range(0, 2) == 0) begin
                new_mem();
            end else if ((mem_rd | mem_wr) && ph == 1 && m_mem && $urandom_range(0, 15) == 0) begin
                mem_rd = 1'b0; mem_wr = 1'b0;
            end
            ram_rdata = $urandom;
            ram_ack   = (ph == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the load/store unit (MEM stage) of the multistage pipeline.
- Latches one request at a time and drives it to the RAM with a req/ack handshake.
- Returns read data to the requester with a one-cycle ready pulse.
- MEM has priority, with a starvation guard that guarantees IF forward progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_MEM_BURST, 4, consecutive MEM grants allowed while IF waits before IF is forced to win

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word
- if_ready  out  1  one-cycle completion pulse for IF
- mem_rd  in  1  load request; held until mem_ready
- mem_wr  in  1  store request; held until mem_ready
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_ls_bit  in  2  access size: 00 word, 01 half, 10 byte, 11 none
- mem_rdata  out  DATA_W  load data
- mem_ready  out  1  one-cycle completion pulse for MEM
- ram_req  out  1  RAM request, held until ram_ack
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_ls_bit  out  2  RAM access size
- ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM completion, single-cycle

Behaviour:
- Clocking: single clock. Reset is synchronous and active-low. Every output is 0 at reset, including rdata registers; the starvation counter is 0; the FSM is in IDLE.
- FSM states:
  - IDLE
  - IF_WAIT, MEM_WAIT
  - IF_DONE, MEM_DONE
- IDLE arbitration, evaluated in priority order:
  - (mem_rd|mem_wr) and not (if_req and starve_cnt==MAX_MEM_BURST) -> MEM_WAIT
  - else if_req -> IF_WAIT
  - else stay in IDLE
- On grant:
  - Latch the address, wdata, ls_bit and we into the ram_* registers and set ram_req=1 on the next cycle.
  - IF grants force ram_we=0 and ram_ls_bit=00.
  - mem_wr with mem_rd: treated as a write; mem_rd is ignored.
- *_WAIT:
  - Hold ram_req and all ram_* outputs stable until ram_ack.
  - On ram_ack: clear ram_req, capture ram_rdata into if_rdata or mem_rdata, and go to the matching *_DONE state.
  - On a write, mem_rdata keeps its previous value.
- *_DONE:
  - Assert if_ready or mem_ready for exactly that cycle.
  - No arbitration occurs in this cycle, so a requester still asserting its request during the ready cycle is never re-granted.
  - Next state is IDLE.
- Latency:
  - Request in IDLE at cycle 0; ram_req at cycle 1.
  - ram_ack at cycle 1+k (k>=0); ready at cycle 2+k.
  - Minimum 2 cycles. Back-to-back throughput is one access per 3+k cycles.
- Starvation counter, saturating at MAX_MEM_BURST:
  - +1 on a MEM grant while if_req=1.
  - Cleared to 0 on an IF grant.
  - Unchanged on a MEM grant with if_req=0.
- Boundary conditions:
  - ram_ack in IDLE or *_DONE: ignored; no state or data change.
  - Request dropped by the requester mid-WAIT: the access still completes, and ready is still pulsed.
  - Reset mid-access: the next edge returns to IDLE with ram_req=0. A late ram_ack is ignored, and the starvation count is cleared.
  - mem_ls_bit=11 with mem_rd/mem_wr: forwarded unchanged; the RAM is responsible for the size.

Decomposition:
- Shared package mips_defs holds:
  - LS-size constants WORD/HALF/BYTE/NONE (2-bit), common to the controller and the RAM
  - arbiter state encoding (3-bit)
  - ADDR_W/DATA_W defaults
- One natural sub-module: arb_starve_cnt, a saturating counter with inc/clr/full.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with if_req=1 -> all outputs 0, no ram_req. Release -> ram_req=1 one cycle later with ram_addr=if_addr, ram_we=0.
- IF read, RAM ack after 3 cycles with ram_rdata=0x2402000A -> if_ready pulses 1 cycle, 5 cycles after the request, with if_rdata=0x2402000A; mem_ready stays 0.
- Simultaneous if_req and mem_wr (addr 0x100, wdata 0xDEADBEEF, ls 10) -> MEM granted first: ram_we=1, ram_ls_bit=10. IF is served immediately after mem_ready.
- Starvation: mem_rd and if_req held continuously, ack k=0 -> exactly 4 MEM grants, then 1 IF grant, then the counter resets and MEM wins again.
- Spurious ram_ack in IDLE, and an ack during a *_DONE cycle -> no ready pulse; rdata unchanged.
- Reset asserted in MEM_WAIT before ack, then ram_ack arrives -> ram_req=0 after the reset edge, mem_ready never pulses, starve_cnt=0.
